// File: rtl/prog_mod_counter_pkg.sv
// rtl/prog_mod_counter_pkg.sv - shared constants and modulus helper for prog_mod_counter
package prog_mod_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam int   WRAPCNT_W = 16;

  // Effective modulus: a stored 0 stands for 2^width, so the result needs one extra bit.
  // Callers pass the modulus zero-extended to 32 bits and truncate the result to WIDTH+1.
  function automatic logic [32:0] eff_mod(input logic [31:0] mod_reg, input int width);
    if (mod_reg == 32'd0) begin
      return 33'd1 << width;
    end
    return {1'b0, mod_reg};
  endfunction

endpackage

// File: rtl/prog_mod_counter_if.sv
// rtl/prog_mod_counter_if.sv - control/status bundle for prog_mod_counter (wrap_cnt under PROG_MOD_COUNTER_WRAPCNT_EN)
interface prog_mod_counter_if
  import prog_mod_counter_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             en;
  logic             up_dn;
  logic             mod_ld;
  logic [WIDTH-1:0] mod_val;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             tc_en;
  logic             wrap;
  logic             err;
`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
  logic [WRAPCNT_W-1:0] wrap_cnt;
`endif

  modport master (
    output en, up_dn, mod_ld, mod_val, load, load_val,
`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
    input  wrap_cnt,
`endif
    input  count, tc, tc_en, wrap, err
  );

  modport slave (
    input  en, up_dn, mod_ld, mod_val, load, load_val,
`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
    output wrap_cnt,
`endif
    output count, tc, tc_en, wrap, err
  );

endinterface

// File: rtl/prog_mod_counter_next.sv
// rtl/prog_mod_counter_next.sv - combinational next-count, wrap and preload-error logic
module prog_mod_counter_next
  import prog_mod_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic [WIDTH-1:0] mod_reg_i,
  input  logic [WIDTH-1:0] mod_val_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_dn_i,
  input  logic             en_i,
  input  logic             mod_ld_i,
  input  logic             load_i,
  output logic [WIDTH-1:0] count_o,
  output logic             wrap_o,
  output logic             err_o
);

  logic [WIDTH:0]   mod_cur;
  logic [WIDTH:0]   mod_new;
  logic [WIDTH:0]   mod_chk;
  logic [WIDTH:0]   count_inc;
  logic [WIDTH-1:0] mod_last;

  assign mod_cur   = (WIDTH+1)'(eff_mod(32'(mod_reg_i), WIDTH));
  assign mod_new   = (WIDTH+1)'(eff_mod(32'(mod_val_i), WIDTH));
  // A preload in the same cycle as a modulus load is validated against the incoming modulus.
  assign mod_chk   = mod_ld_i ? mod_new : mod_cur;
  // One extra bit so M = 2^WIDTH wraps cleanly at all-ones.
  assign count_inc = {1'b0, count_i} + (WIDTH+1)'(1);
  assign mod_last  = WIDTH'(mod_cur - (WIDTH+1)'(1));

  // Priority: modulus load, then preload, then counting.
  always_comb begin
    count_o = count_i;
    wrap_o  = 1'b0;
    err_o   = 1'b0;
    if (mod_ld_i || load_i) begin
      count_o = '0;
      if (load_i) begin
        if ({1'b0, load_val_i} < mod_chk) begin
          count_o = load_val_i;
        end else begin
          err_o = 1'b1;
        end
      end
    end else if (en_i) begin
      if (up_dn_i == DIR_UP) begin
        if (count_inc >= mod_cur) begin
          count_o = '0;
          wrap_o  = 1'b1;
        end else begin
          count_o = count_inc[WIDTH-1:0];
        end
      end else begin
        if (count_i == '0) begin
          count_o = mod_last;
          wrap_o  = 1'b1;
        end else begin
          count_o = count_i - WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: rtl/prog_mod_counter.sv
// rtl/prog_mod_counter.sv - programmable modulo-M up/down counter top (optional wrap_cnt via PROG_MOD_COUNTER_WRAPCNT_EN)
module prog_mod_counter
  import prog_mod_counter_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_MOD = 6
) (
  input logic             clk,
  input logic             rst,
  prog_mod_counter_if.slave bus
);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;
  logic [WIDTH:0]   mod_cur;

  prog_mod_counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .count_i   (count_q),
    .mod_reg_i (mod_q),
    .mod_val_i (bus.mod_val),
    .load_val_i(bus.load_val),
    .up_dn_i   (bus.up_dn),
    .en_i      (bus.en),
    .mod_ld_i  (bus.mod_ld),
    .load_i    (bus.load),
    .count_o   (count_d),
    .wrap_o    (wrap_d),
    .err_o     (err_d)
  );

  assign mod_d = bus.mod_ld ? bus.mod_val : mod_q;

  // Count, modulus and the one-cycle status pulses; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      mod_q   <= WIDTH'(DEFAULT_MOD);
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      mod_q   <= mod_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  // Terminal count depends on the direction currently requested, not the last one used.
  assign mod_cur   = (WIDTH+1)'(eff_mod(32'(mod_q), WIDTH));
  assign bus.tc    = (bus.up_dn == DIR_UP) ? ({1'b0, count_q} == (mod_cur - (WIDTH+1)'(1)))
                                           : (count_q == '0);
  assign bus.tc_en = bus.tc & bus.en;
  assign bus.count = count_q;
  assign bus.wrap  = wrap_q;
  assign bus.err   = err_q;

`ifdef PROG_MOD_COUNTER_WRAPCNT_EN
  logic [WRAPCNT_W-1:0] wrap_cnt_q;

  // Saturating wrap-event counter, cleared whenever the modulus changes.
  always_ff @(posedge clk) begin
    if (rst || bus.mod_ld) begin
      wrap_cnt_q <= '0;
    end else if (wrap_d && (wrap_cnt_q != {WRAPCNT_W{1'b1}})) begin
      wrap_cnt_q <= wrap_cnt_q + WRAPCNT_W'(1);
    end
  end

  assign bus.wrap_cnt = wrap_cnt_q;
`endif

endmodule

// File: doc/prog_mod_counter.md
Name: prog_mod_counter

Overview:
Runtime-programmable modulo-M up/down counter; successor to the fixed-modulus counter.
- Adds count enable, direction control, synchronous preload, runtime modulus register, terminal-count and wrap indications, and load-error flag.
- Used as a timebase/divider and as a chainable digit in multi-stage counters; tc_en of one stage drives en of the next.

Parameters:
WIDTH, 8, counter and modulus width in bits (>=2)
DEFAULT_MOD, 6, modulus loaded into mod_reg at reset; must fit in WIDTH bits

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous active-high reset
en  in  1  count enable
up_dn  in  1  1 = count up, 0 = count down; sampled every enabled cycle
mod_ld  in  1  load mod_val into modulus register
mod_val  in  WIDTH  new modulus
load  in  1  synchronous preload of count
load_val  in  WIDTH  preload value
count  out  WIDTH  current count, range 0..M-1
tc  out  1  combinational terminal count: count==M-1 when up_dn=1, count==0 when up_dn=0
tc_en  out  1  combinational tc & en, cascade carry
wrap  out  1  registered 1-cycle pulse, asserted the cycle after count wrapped
err  out  1  registered 1-cycle pulse, asserted the cycle after an invalid preload

Behaviour:
- Reset (rst=1 at posedge) overrides all other inputs: count=0, mod_reg=DEFAULT_MOD, wrap=0, err=0.
- Effective modulus M = mod_reg. mod_reg==0 means M = 2^WIDTH. mod_reg==1 means count is held at 0; every enabled cycle counts as a wrap.
- Priority when rst=0: mod_ld > load > en.
- mod_ld=1:
  - mod_reg<=mod_val.
  - If load=1 in the same cycle, load_val is validated against the new modulus: load_val<M(mod_val) gives count<=load_val, otherwise count<=0 and err pulse.
  - If load=0, count<=0.
  - en is ignored in this cycle; no wrap.
- load=1, mod_ld=0:
  - If load_val<M, count<=load_val.
  - Otherwise count<=0 and err pulse.
  - en is ignored; no wrap.
- en=1, no load:
  - Up: count<=count+1; at M-1, count<=0 and wrap pulse.
  - Down: count<=count-1; at 0, count<=M-1 and wrap pulse.
- en=0, no load: count holds; wrap=0.
- Latency: count reflects an action 1 cycle after the posedge; wrap/err go high in the same cycle count shows the post-wrap or cleared value.
- Direction change mid-sequence takes effect on the next enabled edge; no wrap unless at the terminal value of the new direction.
- Arithmetic: the count+1 comparison uses WIDTH+1 bits so M=2^WIDTH wraps at all-ones without overflow ambiguity.
- Invariant: count<M after every edge.

Optional Feature:
Macro PROG_MOD_COUNTER_WRAPCNT_EN.
- Defined: adds output wrap_cnt [15:0], incremented on each wrap event and saturating at 16'hFFFF. Cleared by rst and by mod_ld.
- Undefined: port and logic absent; all other behaviour identical.

Decomposition:
- Package prog_mod_counter_pkg:
  - DIR_UP=1'b1, DIR_DOWN=1'b0 constants.
  - Function computing the effective modulus from mod_reg (0 gives 2^WIDTH), returned in WIDTH+1 bits.
  - WRAPCNT_W=16.
- One sub-module is natural: prog_mod_counter_next, combinational next-count/wrap/err logic from (count, mod, up_dn, en, load, load_val). The top holds only registers and tc decode.

Test Plan:
- Reset, then en=1, up_dn=1, default M=6 for 14 cycles -> count 0,1,2,3,4,5,0,1,... ; wrap high on the cycles count returns to 0; tc high at 5.
- mod_ld with mod_val=3, then down-count 7 cycles -> count 0,2,1,0,2,1,0; wrap pulses on 0->2 transitions; tc high at 0.
- With M=6: load load_val=4 -> count=4, err=0. Then load load_val=9 -> count=0, err pulses one cycle.
- mod_val=0 with WIDTH=8, preload 254, count up 3 cycles -> 254,255,0 with wrap on 0. Then mod_val=1 -> count stays 0, wrap every enabled cycle.
- At count=3 (M=6): assert rst together with load=1 and mod_ld=1 -> count=0, mod_reg=6, wrap=0, err=0. Toggle en=0 for 3 cycles -> count holds.
- With PROG_MOD_COUNTER_WRAPCNT_EN: run 10 full wraps at M=2 -> wrap_cnt=10; mod_ld -> wrap_cnt=0. Preload near saturation -> wrap_cnt sticks at 16'hFFFF.
